// File: rtl/reduce_pkg.sv
// Shared definitions for the pipelined reduction tree: operator encoding and
// elaboration-time helpers that size each tree level.
package reduce_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // Number of FANIN-ary levels needed to bring width down to a single bit.
    function automatic int clog_fanin(input int width, input int fanin);
        int w;
        int n;
        w = width;
        n = 0;
        while (w > 1) begin
            w = (w + fanin - 1) / fanin;
            n = n + 1;
        end
        return n;
    endfunction

    // Vector width after 'level' reduction levels (level 0 is the input).
    function automatic int level_width(input int width, input int fanin, input int level);
        int w;
        w = width;
        for (int i = 0; i < level; i++) begin
            w = (w + fanin - 1) / fanin;
        end
        return w;
    endfunction

    // Bit offset of a level inside the flattened all-levels data bus.
    function automatic int level_offset(input int width, input int fanin, input int level);
        int off;
        off = 0;
        for (int i = 0; i < level; i++) begin
            off = off + level_width(width, fanin, i);
        end
        return off;
    endfunction

    // Pad value that leaves a group reduction unchanged.
    function automatic logic identity(input logic [1:0] op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

endpackage

// File: rtl/reduce_stage.sv
// One level of the reduction tree: FANIN-wide group reduction feeding an
// elastic register slice (valid, op and partial vector).
module reduce_stage
    import reduce_pkg::*;
#(
    parameter int IN_W  = 30,
    parameter int FANIN = 4,
    parameter bit LAST  = 1'b0,
    localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_next,
    input  logic              prev_valid,
    input  logic [1:0]        prev_op,
    input  logic [IN_W-1:0]   prev_data,
    output logic              valid,
    output logic [1:0]        op,
    output logic [OUT_W-1:0]  data
);

    localparam int PAD_W = OUT_W * FANIN;

    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] node;
    logic [OUT_W-1:0] data_next;
    logic             en;

    genvar gi;

    // Lanes past the input width take the operator's identity so a short last
    // group reduces exactly like the real lanes alone.
    generate
        for (gi = 0; gi < PAD_W; gi++) begin : gen_pad
            if (gi < IN_W) begin : gen_lane
                assign padded[gi] = prev_data[gi];
            end else begin : gen_ident
                assign padded[gi] = identity(prev_op);
            end
        end

        for (gi = 0; gi < OUT_W; gi++) begin : gen_node
            logic [FANIN-1:0] grp;
            assign grp      = padded[gi*FANIN +: FANIN];
            assign node[gi] = (prev_op == OP_OR)  ? |grp :
                              (prev_op == OP_XOR) ? ^grp : &grp;
        end

        // NAND is carried as AND through the tree and inverted once at the end.
        if (LAST) begin : gen_last
            assign data_next = (prev_op == OP_NAND) ? ~node : node;
        end else begin : gen_mid
            assign data_next = node;
        end
    endgenerate

    assign en = !valid || acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            op    <= 2'b00;
            data  <= '0;
        end else if (en) begin
            valid <= prev_valid;
            op    <= prev_op;
            data  <= data_next;
        end
    end

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined FANIN-ary reduction of a WIDTH-bit vector to one bit, one register
// stage per tree level, with a valid/ready elastic handshake.
module reduce_tree_pipe
    import reduce_pkg::*;
#(
    parameter int WIDTH = 30,
    parameter int FANIN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [1:0]       out_op
);

    localparam int STAGES  = clog_fanin(WIDTH, FANIN);
    localparam int TOTAL_W = level_offset(WIDTH, FANIN, STAGES + 1);

    // Every level's partial vector packed into one bus; level 0 is in_data.
    logic [TOTAL_W-1:0]    data_bus;
    logic [STAGES:0]       v;
    logic [2*STAGES+1:0]   op_bus;

    assign data_bus[WIDTH-1:0] = in_data;
    assign v[0]                = in_valid;
    assign op_bus[1:0]         = in_op;

    genvar gi;

    generate
        for (gi = 0; gi < STAGES; gi++) begin : gen_stage
            localparam int IN_W    = level_width(WIDTH, FANIN, gi);
            localparam int OUT_W   = level_width(WIDTH, FANIN, gi + 1);
            localparam int IN_OFF  = level_offset(WIDTH, FANIN, gi);
            localparam int OUT_OFF = level_offset(WIDTH, FANIN, gi + 1);

            logic acc_next;

            // The unrolled ready chain: downstream accepts if the sink is
            // ready or any later stage holds a bubble.
            if (gi == STAGES - 1) begin : gen_acc_out
                assign acc_next = out_ready;
            end else begin : gen_acc_mid
                assign acc_next = out_ready || !(&v[STAGES:gi+2]);
            end

            reduce_stage #(
                .IN_W  (IN_W),
                .FANIN (FANIN),
                .LAST  (gi == STAGES - 1)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .acc_next   (acc_next),
                .prev_valid (v[gi]),
                .prev_op    (op_bus[2*gi +: 2]),
                .prev_data  (data_bus[IN_OFF +: IN_W]),
                .valid      (v[gi+1]),
                .op         (op_bus[2*gi+2 +: 2]),
                .data       (data_bus[OUT_OFF +: OUT_W])
            );
        end
    endgenerate

    assign in_ready  = out_ready || !(&v[STAGES:1]);
    assign out_valid = v[STAGES];
    assign out_bit   = data_bus[TOTAL_W-1];
    assign out_op    = op_bus[2*STAGES +: 2];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Self-checking bench for reduce_tree_pipe: directed vectors, hand-written
// handshake sequences and a randomized scoreboard run over four configurations.
module tb_reduce_tree_pipe;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam int NCFG = 4;
    localparam int W_TAB [NCFG] = '{30, 7, 64, 2};
    localparam int ST_TAB[NCFG] = '{3, 2, 3, 1};

    typedef struct {
        int          sel;
        logic [63:0] data;
        logic [1:0]  op;
        logic        exp_bit;
    } vec_t;

    typedef struct {
        logic       b;
        logic [1:0] op;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] in_data = '0;
    logic [1:0]  in_op = 2'b00;
    int          sel = 0;

    logic       rdy_a [NCFG];
    logic       ov_a  [NCFG];
    logic       ob_a  [NCFG];
    logic [1:0] oo_a  [NCFG];

    logic       in_ready_m, out_valid_m, out_bit_m;
    logic [1:0] out_op_m;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    logic held = 1'b0;
    logic held_bit;
    logic [1:0] held_op;

    always #5 clk = ~clk;

    reduce_tree_pipe #(.WIDTH(30), .FANIN(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(rdy_a[0]),
        .in_data(in_data[29:0]), .in_op(in_op), .out_valid(ov_a[0]),
        .out_ready(out_ready || sel != 0), .out_bit(ob_a[0]), .out_op(oo_a[0]));
    reduce_tree_pipe #(.WIDTH(7), .FANIN(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(rdy_a[1]),
        .in_data(in_data[6:0]), .in_op(in_op), .out_valid(ov_a[1]),
        .out_ready(out_ready || sel != 1), .out_bit(ob_a[1]), .out_op(oo_a[1]));
    reduce_tree_pipe #(.WIDTH(64), .FANIN(6)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(rdy_a[2]),
        .in_data(in_data[63:0]), .in_op(in_op), .out_valid(ov_a[2]),
        .out_ready(out_ready || sel != 2), .out_bit(ob_a[2]), .out_op(oo_a[2]));
    reduce_tree_pipe #(.WIDTH(2), .FANIN(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3), .in_ready(rdy_a[3]),
        .in_data(in_data[1:0]), .in_op(in_op), .out_valid(ov_a[3]),
        .out_ready(out_ready || sel != 3), .out_bit(ob_a[3]), .out_op(oo_a[3]));

    assign in_ready_m  = rdy_a[sel];
    assign out_valid_m = ov_a[sel];
    assign out_bit_m   = ob_a[sel];
    assign out_op_m    = oo_a[sel];

    // Reference: flat reduction of the low w bits, by population count.
    function automatic logic ref_reduce(input logic [63:0] d, input int w, input logic [1:0] o);
        int ones;
        ones = 0;
        for (int i = 0; i < w; i++) ones += int'(d[i]);
        case (o)
            OP_AND:  return ones == w;
            OP_OR:   return ones > 0;
            OP_XOR:  return ones[0];
            default: return ones != w;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (sel=%0d t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One handshake cycle against the scoreboard; entered and left at posedge+1.
    task automatic cycle_io(input logic iv, input logic [63:0] d, input logic [1:0] o,
                            input logic ordy, output logic acc);
        exp_t e;
        in_valid  = iv;
        in_data   = d;
        in_op     = o;
        out_ready = ordy;
        #1;
        if (held) begin
            check("hold_valid", out_valid_m, 1'b1);
            check("hold_bit", out_bit_m, held_bit);
            check("hold_op", out_op_m, held_op);
        end
        acc = iv && in_ready_m;
        if (out_valid_m && ordy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                $display("out sel=%0d bit=%0b op=%0d", sel, out_bit_m, out_op_m);
                check("sb_bit", out_bit_m, e.b);
                check("sb_op", out_op_m, e.op);
            end
        end
        held     = out_valid_m && !ordy;
        held_bit = out_bit_m;
        held_op  = out_op_m;
        if (acc) begin
            e.b  = ref_reduce(d, W_TAB[sel], o);
            e.op = o;
            exp_q.push_back(e);
        end
        check("inflight_max", 64'(exp_q.size() <= ST_TAB[sel]), 1'b1);
        step();
    endtask

    task automatic flush_sb();
        exp_q.delete();
        held = 1'b0;
    endtask

    vec_t        tbl[9];
    logic [1:0]  sweep_op [4];
    logic        sweep_bit[4];
    logic [63:0] bp_data[5];
    logic [1:0]  bp_op[5];
    int          rnd_n[NCFG];

    initial begin
        logic acc;
        int lat, k, n, cyc, nacc;
        logic [63:0] d;
        logic [1:0] o;

        tbl[0] = '{0, 64'h3FFF_FFFF, OP_AND,  1'b1};
        tbl[1] = '{0, 64'h3FFD_FFFF, OP_AND,  1'b0};
        tbl[2] = '{0, 64'h0,         OP_NAND, 1'b1};
        tbl[3] = '{0, 64'h2000_0000, OP_XOR,  1'b1};
        tbl[4] = '{1, 64'h7F,        OP_AND,  1'b1};
        tbl[5] = '{1, 64'h00,        OP_OR,   1'b0};
        tbl[6] = '{1, 64'h07,        OP_XOR,  1'b1};
        tbl[7] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, OP_NAND, 1'b0};
        tbl[8] = '{3, 64'h2,         OP_AND,  1'b0};
        sweep_op  = '{OP_AND, OP_OR, OP_XOR, OP_NAND};
        sweep_bit = '{1'b0, 1'b1, 1'b1, 1'b1};
        rnd_n     = '{4000, 2000, 2000, 2000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid_m, 1'b0);
        check("rst_out_bit", out_bit_m, 1'b0);
        check("rst_out_op", out_op_m, 2'b00);
        #2 rst_n = 1'b1;
        step();
        for (int s = 0; s < NCFG; s++) begin
            sel = s;
            #0;
            check("rst_in_ready", in_ready_m, 1'b1);
            check("rst_idle_valid", out_valid_m, 1'b0);
        end

        // Directed table: single vector, latency and result
        for (int i = 0; i < 9; i++) begin
            sel = tbl[i].sel;
            in_valid = 1'b1; in_data = tbl[i].data; in_op = tbl[i].op; out_ready = 1'b1;
            #1;
            check("tbl_in_ready", in_ready_m, 1'b1);
            step();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid_m && lat < 10) begin
                step();
                lat++;
            end
            $display("vec %0d sel=%0d data=%0h op=%0d bit=%0b lat=%0d",
                     i, sel, tbl[i].data, tbl[i].op, out_bit_m, lat);
            check("tbl_latency", lat, ST_TAB[sel]);
            check("tbl_bit", out_bit_m, tbl[i].exp_bit);
            check("tbl_op", out_op_m, tbl[i].op);
            step();
        end

        // Back-to-back op sweep: one result per cycle, no gaps
        sel = 0; k = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 4);
            in_data = 64'h1;
            in_op = sweep_op[c % 4];
            out_ready = 1'b1;
            #1;
            if (c < 4) check("b2b_ready", in_ready_m, 1'b1);
            step();
            if (out_valid_m) begin
                $display("sweep out bit=%0b op=%0d cycle=%0d", out_bit_m, out_op_m, c);
                if (k < 4) begin
                    check("b2b_bit", out_bit_m, sweep_bit[k]);
                    check("b2b_op", out_op_m, sweep_op[k]);
                    check("b2b_cycle", c, ST_TAB[0] - 1 + k);
                end
                k++;
            end
        end
        check("b2b_count", k, 4);

        // Back-pressure: out_ready low from cycle 2, release at cycle 8
        sel = 0; flush_sb(); nacc = 0;
        for (int i = 0; i < 5; i++) begin
            bp_data[i] = {$urandom(), $urandom()};
            bp_op[i] = 2'($urandom_range(3));
        end
        for (int c = 0; c < 25; c++) begin
            if (c == 7) begin
                check("bp_in_ready", in_ready_m, 1'b0);
                check("bp_inflight", exp_q.size(), 3);
                check("bp_accepted", nacc, 3);
            end
            cycle_io(nacc < 5, bp_data[nacc % 5], bp_op[nacc % 5], (c < 2 || c >= 8), acc);
            if (acc) nacc++;
        end
        check("bp_all_sent", nacc, 5);
        check("bp_drained", exp_q.size(), 0);

        // Reset with three results in flight
        sel = 0; flush_sb();
        for (int c = 0; c < 3; c++) cycle_io(1'b1, 64'h3FFF_FFFF, OP_AND, 1'b0, acc);
        check("mid_pre_valid", out_valid_m, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_valid", out_valid_m, 1'b0);
        check("mid_async_bit", out_bit_m, 1'b0);
        flush_sb();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("mid_in_ready", in_ready_m, 1'b1);
        for (int c = 0; c < 6; c++) begin
            check("mid_no_stale", out_valid_m, 1'b0);
            cycle_io(1'b0, 64'h0, OP_AND, 1'b1, acc);
        end

        // Randomized scoreboard run across all configurations
        for (int s = 0; s < NCFG; s++) begin
            sel = s; flush_sb(); n = 0; cyc = 0;
            while (n < rnd_n[s] && cyc < rnd_n[s] * 10) begin
                case ($urandom_range(3))
                    0: d = '1;
                    1: d = ~(64'h1 << $urandom_range(W_TAB[s] - 1));
                    2: d = '0;
                    default: d = {$urandom(), $urandom()};
                endcase
                o = 2'($urandom_range(3));
                cycle_io($urandom_range(99) < 75, d, o, $urandom_range(99) < 70, acc);
                if (acc) n++;
                cyc++;
            end
            check("rnd_accepted", n, rnd_n[s]);
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 50) begin
                cycle_io(1'b0, 64'h0, OP_AND, 1'b1, acc);
                cyc++;
            end
            check("rnd_drained", exp_q.size(), 0);
            check("rnd_idle", out_valid_m, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
